// File: rtl/fsk_demod_if.sv
// Sample-in / word-out bundle for the 2-FSK demodulator.
// The master drives DAC samples; the slave returns decoded words and status.
interface fsk_demod_if;
  logic [31:0] tdata_slave;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_err;
  logic        rx_lock;
  logic [4:0]  rx_bit_cnt;

  modport master (
    output tdata_slave,
    input  rx_data,
    input  rx_valid,
    input  rx_err,
    input  rx_lock,
    input  rx_bit_cnt
  );

  modport slave (
    input  tdata_slave,
    output rx_data,
    output rx_valid,
    output rx_err,
    output rx_lock,
    output rx_bit_cnt
  );
endinterface

// File: rtl/fsk_demod.sv
// Binary-FSK demodulator: classifies each sine cycle by its length between
// rising midscale crossings and packs the bits LSB-first into 32-bit words.
module fsk_demod #(
  parameter logic [15:0] MID_CODE = 16'h8000,
  parameter logic [15:0] HYST     = 16'd1024,
  parameter logic [10:0] T_SPLIT  = 11'd902,
  parameter logic [10:0] T_MIN    = 11'd600,
  parameter logic [10:0] T_MAX    = 11'd1300
) (
  input logic        clk,
  input logic        rst,
  fsk_demod_if.slave bus
);

  typedef enum logic {SYNC, RUN} state_t;

  localparam logic [16:0] HI_TH = {1'b0, MID_CODE} + {1'b0, HYST};
  localparam logic [16:0] LO_TH = {1'b0, MID_CODE} - {1'b0, HYST};
  localparam logic        LO_OK = (MID_CODE >= HYST);
  localparam logic [10:0] T_TO  = T_MAX + 11'd1;

  state_t      r_state;
  logic [15:0] r_samp;
  logic        r_hi;
  logic        r_hi_d;
  logic        r_xc;
  logic [10:0] r_cnt;
  logic [31:0] r_sh;
  logic [31:0] r_data;
  logic        r_valid;
  logic        r_err;
  logic        r_lock;
  logic [4:0]  r_bit_cnt;

  logic        w_set;
  logic        w_clr;
  logic        w_legal;
  logic        w_bit;
  logic [31:0] w_sh;
  logic        w_unused;

  assign w_unused = ^bus.tdata_slave[31:16];

  // Lower threshold is disabled if it would fall below code 0.
  assign w_set   = ({1'b0, r_samp} > HI_TH);
  assign w_clr   = LO_OK && ({1'b0, r_samp} < LO_TH);
  assign w_legal = (r_cnt >= T_MIN) && (r_cnt <= T_MAX);
  assign w_bit   = (r_cnt <= T_SPLIT);

  always_comb begin
    w_sh = r_sh;
    w_sh[r_bit_cnt] = w_bit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= SYNC;
      r_samp    <= '0;
      r_hi      <= 1'b0;
      r_hi_d    <= 1'b0;
      r_xc      <= 1'b0;
      r_cnt     <= '0;
      r_sh      <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_lock    <= 1'b0;
      r_bit_cnt <= '0;
    end else begin
      r_samp  <= bus.tdata_slave[15:0];
      r_hi_d  <= r_hi;
      r_xc    <= r_hi & ~r_hi_d;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (w_set)
        r_hi <= 1'b1;
      else if (w_clr)
        r_hi <= 1'b0;
      if (r_xc)
        r_cnt <= 11'd1;
      else if (r_cnt != 11'h7FF)
        r_cnt <= r_cnt + 11'd1;
      case (r_state)
        SYNC: begin
          if (r_xc) begin
            r_state   <= RUN;
            r_lock    <= 1'b1;
            r_sh      <= '0;
            r_bit_cnt <= '0;
          end
        end
        RUN: begin
          if (r_xc && w_legal) begin
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'd31) begin
              r_data  <= w_sh;
              r_valid <= 1'b1;
              r_sh    <= '0;
            end else begin
              r_sh <= w_sh;
            end
          end else if (r_xc) begin
            // Bad period: this crossing restarts bit 0.
            r_err     <= 1'b1;
            r_sh      <= '0;
            r_bit_cnt <= '0;
          end else if (r_cnt == T_TO) begin
            r_err     <= 1'b1;
            r_sh      <= '0;
            r_bit_cnt <= '0;
            r_state   <= SYNC;
            r_lock    <= 1'b0;
          end
        end
        default: r_state <= SYNC;
      endcase
    end
  end

  assign bus.rx_data    = r_data;
  assign bus.rx_valid   = r_valid;
  assign bus.rx_err     = r_err;
  assign bus.rx_lock    = r_lock;
  assign bus.rx_bit_cnt = r_bit_cnt;

endmodule

// File: doc/fsk_demod.md
# fsk_demod

Binary-FSK demodulator for the 2-FSK link; receiver-side counterpart of the sine-LUT FSK modulator. Consumes one 16-bit DAC-code sample per clock. Classifies each bit by the clock length of its sine cycle, measured between rising midscale crossings. Reassembles 32-bit words LSB-first and presents them with a one-cycle valid strobe.

## Interface
Parameters:
- MID_CODE, 16'h8000: unsigned midscale code of the sine.
- HYST, 16'd1024: hysteresis half-width around MID_CODE.
- T_SPLIT, 11'd902: period ≤ T_SPLIT decodes '1' (nominal 722 clk), otherwise '0' (nominal 1083 clk).
- T_MIN, 11'd600: shortest legal cycle period.
- T_MAX, 11'd1300: longest legal cycle period; also the timeout.

Ports:
- clk, in, 1: sole clock.
- rst, in, 1: reset, asynchronous, active-high.
- tdata_slave, in, 32: sample bus; [15:0] is the unsigned DAC code (one sample every clk), [31:16] is ignored.
- rx_data, out, 32: last complete word, bit 0 received first.
- rx_valid, out, 1: one-clk pulse when rx_data updates.
- rx_err, out, 1: one-clk pulse on an illegal period or a timeout.
- rx_lock, out, 1: high while in RUN.
- rx_bit_cnt, out, 5: bits already accumulated into the current word.

## Operation
- Stage 1: samp <= tdata_slave[15:0].
- Stage 2, hysteresis comparator `hi`:
  - Sets when samp > MID_CODE+HYST.
  - Clears when samp < MID_CODE−HYST.
  - Otherwise holds. Comparisons are 17-bit unsigned, with no wrap.
  - Reset value is 0, so the first rise after reset counts as a crossing.
- Crossing event `xc` = `hi` is 1 now and was 0 last cycle (rising edge only).
- Period counter `cnt`:
  - 11 bits, increments every clk, saturates at 2047.
  - Loads 1 on `xc`.
- FSM states are SYNC and RUN. Reset state is SYNC.
- SYNC:
  - `cnt` is ignored.
  - On `xc`, go to RUN. Clear the shift register and rx_bit_cnt.
- RUN, on `xc`, with period p = cnt value before the load:
  - If T_MIN ≤ p ≤ T_MAX: shift bit (p ≤ T_SPLIT ? 1 : 0) into position rx_bit_cnt; rx_bit_cnt += 1 (5-bit wrap).
  - When that was bit 31: rx_data <= word including the new bit, pulse rx_valid, rx_bit_cnt becomes 0.
  - If p < T_MIN or p > T_MAX: pulse rx_err, discard the partial word, set rx_bit_cnt to 0, stay in RUN. This crossing is the new start of bit 0.
- RUN, with no `xc` and cnt reaching T_MAX+1: pulse rx_err once, discard the partial word, go to SYNC.
- Simultaneous events:
  - `xc` in the same clk as timeout: the `xc` branch wins and is an error (p > T_MAX), so the block stays in RUN.
  - rx_valid and rx_err are never high together.
- Word alignment: bit 0 is the first cycle after the crossing that entered RUN or resynchronised. The stream is continuous; the crossing that ends bit 31 also starts the next word's bit 0.
- rx_data holds its value between words. It is not cleared on error, only on reset.

## Timing
- Reset values: rx_data=0, rx_valid=0, rx_err=0, rx_lock=0, rx_bit_cnt=0, samp=0, hi=0, cnt=0, state=SYNC.
- Asynchronous assert, synchronous-to-clk release as is; no sample is processed while rst=1.
- Latency:
  - Sample crossing the threshold at the input at edge n produces `xc` at edge n+2.
  - The bit shift, rx_bit_cnt update, rx_valid/rx_err and rx_data all register at edge n+3.
- rx_lock = (state==RUN). Registered; rises at the same edge as the SYNC→RUN transition.
- Reset mid-word: the partial word is lost, and the next rising crossing starts a fresh bit 0.
- Throughput: one word per 32 symbol cycles (23104–34656 clk nominal). No backpressure; the consumer must accept rx_valid when it is asserted.

## Test plan
- Modulator model driving word 32'hA5A50F0F continuously from reset:
  - rx_data = 32'hA5A50F0F.
  - rx_valid pulses exactly 3 clk after the sample that completes cycle 32.
  - rx_lock = 1 from the first crossing; rx_err never asserts.
- Synthetic cycles of lengths 722 ×32, then 1083 ×32:
  - rx_data = 32'hFFFFFFFF, then 32'h00000000.
  - rx_bit_cnt steps 0..31..0.
- Boundary periods 600, 902, 903, 1300:
  - Bits decoded 1, 1, 0, 0; no error.
  - Periods 599 and 1301 each give one rx_err pulse, rx_bit_cnt=0, rx_lock stays 1.
- Input held at MID_CODE for 2000 clk after 10 good bits:
  - Single rx_err pulse at cnt=1301; rx_lock falls.
  - The next good stream relocks and decodes its first full word correctly.
- rst asserted for 3 clk at bit 17 of a word:
  - All outputs 0 asynchronously.
  - After release, the next word decodes correctly; the interrupted word is never presented.
- Noise of ±HYST/2 around midscale superimposed on a valid stream: no extra crossings and an identical rx_data sequence.
